tdp_ram_arbiter: RTL and testbench

- Front-end controller for the 64x8 true dual-port RAM (registered q, one-cycle read latency).
- Two requesters (A, B) use valid/ready handshakes, and each maps onto its own RAM port.
- Same-address hazards (write/write, write/read) are serialised with round-robin priority instead of reaching the RAM.
- Also sequences a 32-cycle clear of the whole array and counts serialised conflicts.

---
 rtl/tdp_ram_arbiter_if.sv | 25 ++
 rtl/tdp_ram_arbiter.sv | 154 +++++++++++++++
 tb/tb_tdp_ram_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdp_ram_arbiter_if.sv
// ============================================================================
// Module      : tdp_ram_arbiter_if
// Description : Requester-side valid/ready request bus with read response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface tdp_ram_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          valid;
    logic          ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
    modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/tdp_ram_arbiter.sv
// ============================================================================
// Module      : tdp_ram_arbiter
// Description : Two-requester front end for a true dual-port RAM with
//               same-address hazard serialisation and full-array clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tdp_ram_arbiter #(
    parameter int AW = 6,
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    tdp_ram_arbiter_if.slave   a,
    tdp_ram_arbiter_if.slave   b,
    input  wire logic          clear_start,
    output logic               busy,
    output logic               clear_done,
    output logic [CW-1:0]      conflict_cnt,
    output logic               ram_we_a,
    output logic [AW-1:0]      ram_addr_a,
    output logic [DW-1:0]      ram_data_a,
    input  wire logic [DW-1:0] ram_q_a,
    output logic               ram_we_b,
    output logic [AW-1:0]      ram_addr_b,
    output logic [DW-1:0]      ram_data_b,
    input  wire logic [DW-1:0] ram_q_b
);

    localparam int            IW          = AW - 1;
    localparam logic [IW-1:0] C_IDX_LAST  = '1;
    localparam logic [IW-1:0] C_IDX_ONE   = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_CNT_MAX   = '1;
    localparam logic [CW-1:0] C_CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    logic          r_pri;          // 0: A wins the next conflict, 1: B wins
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_a_rvalid;
    logic          r_b_rvalid;
    logic [DW-1:0] r_a_hold;
    logic [DW-1:0] r_b_hold;
    logic          r_clear_done;

    logic w_idle;
    logic w_conflict;
    logic w_a_ready;
    logic w_b_ready;
    logic w_a_acc;
    logic w_b_acc;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_conflict = a.valid & b.valid & (a.addr == b.addr) & (a.we | b.we);

    always_comb begin
        w_a_ready = 1'b0;
        w_b_ready = 1'b0;
        if (w_idle) begin
            if (w_conflict) begin
                w_a_ready = a.valid & ~r_pri;
                w_b_ready = b.valid &  r_pri;
            end else begin
                w_a_ready = a.valid;
                w_b_ready = b.valid;
            end
        end
    end

    assign w_a_acc = a.valid & w_a_ready;
    assign w_b_acc = b.valid & w_b_ready;
    assign a.ready = w_a_ready;
    assign b.ready = w_b_ready;

    // Clear writes the even/odd address pair of one index per cycle.
    always_comb begin
        if (r_state == ST_CLEAR) begin
            ram_we_a   = 1'b1;
            ram_addr_a = {r_idx, 1'b0};
            ram_data_a = '0;
            ram_we_b   = 1'b1;
            ram_addr_b = {r_idx, 1'b1};
            ram_data_b = '0;
        end else begin
            ram_we_a   = w_a_acc & a.we;
            ram_addr_a = a.addr;
            ram_data_a = a.wdata;
            ram_we_b   = w_b_acc & b.we;
            ram_addr_b = b.addr;
            ram_data_b = b.wdata;
        end
    end

    // RAM q is passed straight through on the response cycle, then held.
    assign a.rvalid     = r_a_rvalid;
    assign b.rvalid     = r_b_rvalid;
    assign a.rdata      = r_a_rvalid ? ram_q_a : r_a_hold;
    assign b.rdata      = r_b_rvalid ? ram_q_b : r_b_hold;
    assign busy         = (r_state == ST_CLEAR);
    assign clear_done   = r_clear_done;
    assign conflict_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pri        <= 1'b0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_a_rvalid   <= 1'b0;
            r_b_rvalid   <= 1'b0;
            r_a_hold     <= '0;
            r_b_hold     <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_a_rvalid   <= w_a_acc & ~a.we;
            r_b_rvalid   <= w_b_acc & ~b.we;
            r_clear_done <= 1'b0;
            if (r_a_rvalid) r_a_hold <= ram_q_a;
            if (r_b_rvalid) r_b_hold <= ram_q_b;

            case (r_state)
                ST_IDLE: begin
                    if (w_conflict) begin
                        r_pri <= ~r_pri;
                        if (r_cnt != C_CNT_MAX) r_cnt <= r_cnt + C_CNT_ONE;
                    end
                    if (clear_start) begin
                        r_state <= ST_CLEAR;
                        r_idx   <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_idx <= r_idx + C_IDX_ONE;
                    if (r_idx == C_IDX_LAST) begin
                        r_state      <= ST_IDLE;
                        r_clear_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tdp_ram_arbiter.sv
// ============================================================================
// Module      : tb_tdp_ram_arbiter
// Description : Self-checking bench for tdp_ram_arbiter with a behavioural
//               64x8 registered-output dual-port RAM and read scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tdp_ram_arbiter;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          clear_start;
    logic          busy;
    logic          clear_done;
    logic [CW-1:0] conflict_cnt;
    logic          ram_we_a, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_data_a, ram_data_b;
    logic [DW-1:0] ram_q_a, ram_q_b;

    tdp_ram_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
    tdp_ram_arbiter_if #(.AW(AW), .DW(DW)) b_if ();

    tdp_ram_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a_if),
        .b            (b_if),
        .clear_start  (clear_start),
        .busy         (busy),
        .clear_done   (clear_done),
        .conflict_cnt (conflict_cnt),
        .ram_we_a     (ram_we_a),
        .ram_addr_a   (ram_addr_a),
        .ram_data_a   (ram_data_a),
        .ram_q_a      (ram_q_a),
        .ram_we_b     (ram_we_b),
        .ram_addr_b   (ram_addr_b),
        .ram_data_b   (ram_data_b),
        .ram_q_b      (ram_q_b)
    );

    // Behavioural true dual-port RAM, registered q, not affected by reset.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
        ram_q_a <= mem[ram_addr_a];
        ram_q_b <= mem[ram_addr_b];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] model [0:(1<<AW)-1];
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];

    // Scoreboard: expected read data is queued on acceptance and compared
    // against the response one cycle later.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst_n) begin
            if (a_if.rvalid) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_bad++; $display("FAIL sb_a_unexpected: rvalid=1 with no read pending, required rvalid=0");
                end else begin
                    e = qa.pop_front();
                    if (a_if.rdata !== e) begin
                        n_bad++; $display("FAIL sb_a_rdata: got %h required %h", a_if.rdata, e);
                    end
                end
            end else if (qa.size() != 0) begin
                n_cmp++; n_bad++; qa.delete();
                $display("FAIL sb_a_missing: rvalid=0 required rvalid=1");
            end
            if (b_if.rvalid) begin
                n_cmp++;
                if (qb.size() == 0) begin
                    n_bad++; $display("FAIL sb_b_unexpected: rvalid=1 with no read pending, required rvalid=0");
                end else begin
                    e = qb.pop_front();
                    if (b_if.rdata !== e) begin
                        n_bad++; $display("FAIL sb_b_rdata: got %h required %h", b_if.rdata, e);
                    end
                end
            end else if (qb.size() != 0) begin
                n_cmp++; n_bad++; qb.delete();
                $display("FAIL sb_b_missing: rvalid=0 required rvalid=1");
            end
            if (a_if.valid && a_if.ready) begin
                if (a_if.we) model[a_if.addr] = a_if.wdata;
                else         qa.push_back(model[a_if.addr]);
            end
            if (b_if.valid && b_if.ready) begin
                if (b_if.we) model[b_if.addr] = b_if.wdata;
                else         qb.push_back(model[b_if.addr]);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_all();
        a_if.valid = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.valid = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;
        clear_start = 1'b0;
    endtask

    task automatic drive_a(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_if.valid = 1'b1; a_if.we = we; a_if.addr = ad; a_if.wdata = d;
    endtask

    task automatic drive_b(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_if.valid = 1'b1; b_if.we = we; b_if.addr = ad; b_if.wdata = d;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_cmp++; if (clear_done !== 1'b0) begin n_bad++; $display("FAIL rst_clear_done: got %b required 0", clear_done); end
        n_cmp++; if (conflict_cnt !== '0) begin n_bad++; $display("FAIL rst_cnt: got %0d required 0", conflict_cnt); end
        n_cmp++; if ({a_if.rvalid, b_if.rvalid} !== 2'b00) begin n_bad++; $display("FAIL rst_rvalid: got %b required 00", {a_if.rvalid, b_if.rvalid}); end
        n_cmp++; if ({a_if.rdata, b_if.rdata} !== '0) begin n_bad++; $display("FAIL rst_rdata: got %h required 0", {a_if.rdata, b_if.rdata}); end
        n_cmp++; if ({ram_we_a, ram_we_b} !== 2'b00) begin n_bad++; $display("FAIL rst_ram_we: got %b required 00", {ram_we_a, ram_we_b}); end
        qa.delete(); qb.delete();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_read_a();
        drive_a(1'b1, 6'd3, 8'h5A);
        @(negedge clk);
        n_cmp++; if (a_if.ready !== 1'b1) begin n_bad++; $display("FAIL wr_a_ready: got %b required 1", a_if.ready); end
        n_cmp++; if (ram_we_a !== 1'b1) begin n_bad++; $display("FAIL wr_a_ram_we: got %b required 1", ram_we_a); end
        step();
        drive_a(1'b0, 6'd3, 8'h00);
        @(negedge clk);
        n_cmp++; if (a_if.ready !== 1'b1) begin n_bad++; $display("FAIL rd_a_ready: got %b required 1", a_if.ready); end
        n_cmp++; if (ram_we_a !== 1'b0) begin n_bad++; $display("FAIL rd_a_ram_we: got %b required 0", ram_we_a); end
        step();
        idle_all();
        @(negedge clk);
        n_cmp++; if ({a_if.rvalid, a_if.rdata} !== {1'b1, 8'h5A}) begin n_bad++; $display("FAIL rd_a_data: got %b/%h required 1/5a", a_if.rvalid, a_if.rdata); end
        step();
        @(negedge clk);
        n_cmp++; if (a_if.rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_a_pulse: got %b required 0", a_if.rvalid); end
        n_cmp++; if (conflict_cnt !== 4'd0) begin n_bad++; $display("FAIL wr_rd_cnt: got %0d required 0", conflict_cnt); end
    endtask

    task automatic test_same_read();
        step();
        drive_a(1'b1, 6'd7, 8'h11);
        step();
        drive_a(1'b0, 6'd7, 8'h00);
        drive_b(1'b0, 6'd7, 8'h00);
        @(negedge clk);
        n_cmp++; if ({a_if.ready, b_if.ready} !== 2'b11) begin n_bad++; $display("FAIL rr_ready: got %b required 11", {a_if.ready, b_if.ready}); end
        step();
        idle_all();
        @(negedge clk);
        n_cmp++; if ({a_if.rvalid, b_if.rvalid, a_if.rdata, b_if.rdata} !== {2'b11, 8'h11, 8'h11}) begin
            n_bad++; $display("FAIL rr_data: got %b%b/%h/%h required 11/11/11", a_if.rvalid, b_if.rvalid, a_if.rdata, b_if.rdata);
        end
        n_cmp++; if (conflict_cnt !== 4'd0) begin n_bad++; $display("FAIL rr_cnt: got %0d required 0", conflict_cnt); end
        step();
    endtask

    task automatic test_ww_conflict();
        drive_a(1'b1, 6'd9, 8'hAA);
        drive_b(1'b1, 6'd9, 8'hBB);
        @(negedge clk);
        n_cmp++; if ({a_if.ready, b_if.ready} !== 2'b10) begin n_bad++; $display("FAIL ww_c0_ready: got %b required 10", {a_if.ready, b_if.ready}); end
        step();
        a_if.valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (b_if.ready !== 1'b1) begin n_bad++; $display("FAIL ww_c1_ready: got %b required 1", b_if.ready); end
        step();
        idle_all();
        drive_a(1'b0, 6'd9, 8'h00);
        step();
        idle_all();
        @(negedge clk);
        n_cmp++; if (a_if.rdata !== 8'hBB) begin n_bad++; $display("FAIL ww_rdata: got %h required bb", a_if.rdata); end
        n_cmp++; if (conflict_cnt !== 4'd1) begin n_bad++; $display("FAIL ww_cnt: got %0d required 1", conflict_cnt); end
        step();
    endtask

    task automatic test_wr_conflict();
        // Round 1: priority starts at A after reset.
        drive_a(1'b1, 6'd4, 8'h33);
        drive_b(1'b0, 6'd4, 8'h00);
        @(negedge clk);
        n_cmp++; if ({a_if.ready, b_if.ready} !== 2'b10) begin n_bad++; $display("FAIL wr1_ready: got %b required 10", {a_if.ready, b_if.ready}); end
        step();
        a_if.valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (b_if.ready !== 1'b1) begin n_bad++; $display("FAIL wr1_b_retry: got %b required 1", b_if.ready); end
        step();
        idle_all();
        @(negedge clk);
        n_cmp++; if ({b_if.rvalid, b_if.rdata} !== {1'b1, 8'h33}) begin n_bad++; $display("FAIL wr1_b_data: got %b/%h required 1/33", b_if.rvalid, b_if.rdata); end
        step();
        // Round 2: loser of round 1 now has priority.
        drive_a(1'b1, 6'd4, 8'h44);
        drive_b(1'b0, 6'd4, 8'h00);
        @(negedge clk);
        n_cmp++; if ({a_if.ready, b_if.ready} !== 2'b01) begin n_bad++; $display("FAIL wr2_ready: got %b required 01", {a_if.ready, b_if.ready}); end
        step();
        b_if.valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_if.ready !== 1'b1) begin n_bad++; $display("FAIL wr2_a_retry: got %b required 1", a_if.ready); end
        n_cmp++; if ({b_if.rvalid, b_if.rdata} !== {1'b1, 8'h33}) begin n_bad++; $display("FAIL wr2_b_data: got %b/%h required 1/33", b_if.rvalid, b_if.rdata); end
        step();
        idle_all();
        @(negedge clk);
        n_cmp++; if (conflict_cnt !== 4'd2) begin n_bad++; $display("FAIL wr_cnt: got %0d required 2", conflict_cnt); end
        step();
    endtask

    task automatic test_saturation();
        drive_a(1'b1, 6'd20, 8'h01);
        drive_b(1'b1, 6'd20, 8'h02);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 5) begin
                n_cmp++; if (conflict_cnt !== 4'd7) begin n_bad++; $display("FAIL sat_mid: got %0d required 7", conflict_cnt); end
            end
            step();
        end
        idle_all();
        @(negedge clk);
        n_cmp++; if (conflict_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_cnt: got %0d required 15", conflict_cnt); end
        step();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 32; i++) begin
            drive_a(1'b1, 6'(i), 8'(i + 1));
            drive_b(1'b1, 6'(i + 32), 8'(i + 8'h81));
            step();
        end
        idle_all();
        drive_a(1'b0, 6'd5, 8'h00);
        clear_start = 1'b1;
        @(negedge clk);
        n_cmp++; if (a_if.ready !== 1'b1) begin n_bad++; $display("FAIL clr_pre_ready: got %b required 1", a_if.ready); end
        step();
        clear_start = 1'b0;
        drive_a(1'b0, 6'd1, 8'h00);
        drive_b(1'b0, 6'd2, 8'h00);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_cmp++; if ({a_if.rvalid, a_if.rdata} !== {1'b1, 8'h06}) begin n_bad++; $display("FAIL clr_rvalid: got %b/%h required 1/06", a_if.rvalid, a_if.rdata); end
            end
            n_cmp++; if ({busy, a_if.ready, b_if.ready, clear_done} !== 4'b1000) begin
                n_bad++; $display("FAIL clr_cycle%0d: busy/ra/rb/done got %b required 1000", k, {busy, a_if.ready, b_if.ready, clear_done});
            end
            if (k == 31) begin
                a_if.valid = 1'b0; b_if.valid = 1'b0;
            end
            step();
        end
        @(negedge clk);
        n_cmp++; if ({busy, clear_done} !== 2'b01) begin n_bad++; $display("FAIL clr_done: busy/done got %b required 01", {busy, clear_done}); end
        for (int i = 0; i < 64; i++) model[i] = '0;
        step();
        @(negedge clk);
        n_cmp++; if (clear_done !== 1'b0) begin n_bad++; $display("FAIL clr_done_pulse: got %b required 0", clear_done); end
        step();
        for (int i = 0; i < 32; i++) begin
            drive_a(1'b0, 6'(i), 8'h00);
            drive_b(1'b0, 6'(i + 32), 8'h00);
            step();
        end
        idle_all();
        step();
        step();
    endtask

    task automatic test_reset_mid_clear();
        drive_a(1'b1, 6'd0, 8'h66);
        drive_b(1'b1, 6'd40, 8'h77);
        step();
        idle_all();
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, clear_done} !== 2'b00) begin n_bad++; $display("FAIL abort_busy: busy/done got %b required 00", {busy, clear_done}); end
        for (int i = 0; i < 20; i++) model[i] = '0;
        qa.delete(); qb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if ({busy, clear_done} !== 2'b00) begin n_bad++; $display("FAIL abort_after%0d: busy/done got %b required 00", k, {busy, clear_done}); end
            step();
        end
        drive_a(1'b0, 6'd0, 8'h00);
        drive_b(1'b0, 6'd40, 8'h00);
        step();
        idle_all();
        @(negedge clk);
        n_cmp++; if ({a_if.rdata, b_if.rdata} !== {8'h00, 8'h77}) begin n_bad++; $display("FAIL abort_rdata: got %h/%h required 00/77", a_if.rdata, b_if.rdata); end
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]   = 8'(i) ^ 8'hC3;
            model[i] = 8'(i) ^ 8'hC3;
        end
        rst_n = 1'b0;
        idle_all();
        test_reset();
        test_write_read_a();
        test_same_read();
        test_ww_conflict();
        test_reset();
        test_wr_conflict();
        test_saturation();
        test_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
